// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI4-Lite slave frontend: response codes,
// frontend FSM states and the backend request record.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_RSP,
        S_BRESP,
        S_RRESP
    } fe_state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic [2:0]  prot;
    } axi_lite_req_t;

endpackage

// File: rtl/axi_lite_skid_slot.sv
// Single-entry holding buffer: accepts one beat when empty and keeps it
// until the owner frees it. Ready is registered and equals "slot empty".
module axi_lite_skid_slot #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    input  logic         free_i,
    output logic         full_o,
    output logic [W-1:0] data_o
);

    logic         full_q, full_d, rdy_q;
    logic [W-1:0] data_q, data_d;

    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (in_valid_i && rdy_q) begin
            full_d = 1'b1;
            data_d = in_data_i;
        end
        // ready is low while full, so a free never coincides with a capture
        if (free_i) full_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q <= 1'b0;
            rdy_q  <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            rdy_q  <= !full_d;
            data_q <= data_d;
        end
    end

    assign in_ready_o = rdy_q;
    assign full_o     = full_q;
    assign data_o     = data_q;

endmodule

// File: rtl/axi_lite_slave_frontend.sv
// AXI4-Lite slave frontend: buffers AW/W/AR, issues one backend request at a
// time with write/read round-robin, and returns B/R with a response timeout.
module axi_lite_slave_frontend
    import axi_lite_pkg::*;
#(
    parameter int AW_AXI         = 32,
    parameter int DW_AXI         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  axi_clk,
    input  logic                  sys_areset,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [AW_AXI-1:0]     s_axi_awaddr,
    input  logic [2:0]            s_axi_awprot,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    input  logic [DW_AXI-1:0]     s_axi_wdata,
    input  logic [DW_AXI/8-1:0]   s_axi_wstrb,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    output logic [1:0]            s_axi_bresp,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    input  logic [AW_AXI-1:0]     s_axi_araddr,
    input  logic [2:0]            s_axi_arprot,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    output logic [DW_AXI-1:0]     s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  req_valid,
    input  logic                  req_ready,
    output logic                  req_write,
    output logic [AW_AXI-1:0]     req_addr,
    output logic [DW_AXI-1:0]     req_wdata,
    output logic [DW_AXI/8-1:0]   req_be,
    output logic [2:0]            req_prot,
    input  logic                  rsp_valid,
    input  logic [DW_AXI-1:0]     rsp_rdata,
    input  logic [1:0]            rsp_resp
);

    localparam int BW = DW_AXI / 8;
    localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] TLIM = CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    logic                aw_full, w_full, ar_full, free_wr, free_rd;
    logic [AW_AXI+2:0]   aw_buf, ar_buf;
    logic [DW_AXI+BW-1:0] w_buf;

    axi_lite_skid_slot #(.W(AW_AXI+3)) u_aw (
        .clk(axi_clk), .rst(sys_areset), .in_valid_i(s_axi_awvalid), .in_ready_o(s_axi_awready),
        .in_data_i({s_axi_awprot, s_axi_awaddr}), .free_i(free_wr), .full_o(aw_full), .data_o(aw_buf));
    axi_lite_skid_slot #(.W(DW_AXI+BW)) u_w (
        .clk(axi_clk), .rst(sys_areset), .in_valid_i(s_axi_wvalid), .in_ready_o(s_axi_wready),
        .in_data_i({s_axi_wstrb, s_axi_wdata}), .free_i(free_wr), .full_o(w_full), .data_o(w_buf));
    axi_lite_skid_slot #(.W(AW_AXI+3)) u_ar (
        .clk(axi_clk), .rst(sys_areset), .in_valid_i(s_axi_arvalid), .in_ready_o(s_axi_arready),
        .in_data_i({s_axi_arprot, s_axi_araddr}), .free_i(free_rd), .full_o(ar_full), .data_o(ar_buf));

    fe_state_e          state_q, state_d;
    logic               cur_wr_q, cur_wr_d, last_wr_q, last_wr_d;
    logic [1:0]         resp_q, resp_d;
    logic [DW_AXI-1:0]  rdata_q, rdata_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               wr_pend, rd_pend;

    assign wr_pend = aw_full && w_full;
    assign rd_pend = ar_full;

    always_comb begin
        state_d   = state_q;
        cur_wr_d  = cur_wr_q;
        last_wr_d = last_wr_q;
        resp_d    = resp_q;
        rdata_d   = rdata_q;
        cnt_d     = cnt_q;
        free_wr   = 1'b0;
        free_rd   = 1'b0;
        case (state_q)
            S_IDLE: if (wr_pend || rd_pend) begin
                state_d  = S_REQ;
                cur_wr_d = wr_pend && (!rd_pend || !last_wr_q);
                // the pointer only moves when both types actually competed
                if (wr_pend && rd_pend) last_wr_d = cur_wr_d;
            end
            S_REQ: if (req_ready) begin
                state_d = S_WAIT_RSP;
                cnt_d   = '0;
            end
            S_WAIT_RSP: begin
                if (rsp_valid) begin
                    resp_d  = rsp_resp;
                    rdata_d = rsp_rdata;
                    state_d = cur_wr_q ? S_BRESP : S_RRESP;
                end else if (TIMEOUT_CYCLES != 0 && cnt_q == TLIM) begin
                    resp_d  = RESP_SLVERR;
                    rdata_d = '0;
                    state_d = cur_wr_q ? S_BRESP : S_RRESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_BRESP: if (s_axi_bready) begin
                free_wr = 1'b1;
                state_d = S_IDLE;
            end
            S_RRESP: if (s_axi_rready) begin
                free_rd = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge axi_clk or posedge sys_areset) begin
        if (sys_areset) begin
            state_q   <= S_IDLE;
            cur_wr_q  <= 1'b0;
            last_wr_q <= 1'b0;
            resp_q    <= RESP_OKAY;
            rdata_q   <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            cur_wr_q  <= cur_wr_d;
            last_wr_q <= last_wr_d;
            resp_q    <= resp_d;
            rdata_q   <= rdata_d;
            cnt_q     <= cnt_d;
        end
    end

    assign req_valid = (state_q == S_REQ);
    assign req_write = req_valid && cur_wr_q;
    assign req_addr  = !req_valid ? '0 : (cur_wr_q ? aw_buf[AW_AXI-1:0] : ar_buf[AW_AXI-1:0]);
    assign req_prot  = !req_valid ? '0 : (cur_wr_q ? aw_buf[AW_AXI+2:AW_AXI] : ar_buf[AW_AXI+2:AW_AXI]);
    assign req_wdata = req_write ? w_buf[DW_AXI-1:0] : '0;
    assign req_be    = !req_valid ? '0 : (cur_wr_q ? w_buf[DW_AXI+BW-1:DW_AXI] : '1);

    assign s_axi_bvalid = (state_q == S_BRESP);
    assign s_axi_bresp  = s_axi_bvalid ? resp_q : RESP_OKAY;
    assign s_axi_rvalid = (state_q == S_RRESP);
    assign s_axi_rresp  = s_axi_rvalid ? resp_q : RESP_OKAY;
    assign s_axi_rdata  = s_axi_rvalid ? rdata_q : '0;

endmodule

// File: tb/tb_axi_lite_slave_frontend.sv
// Scenario bench for axi_lite_slave_frontend: expected backend requests and
// B/R responses are queued when stimulus is driven and popped on DUT output.
module tb_axi_lite_slave_frontend;

    localparam int TO = 8;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic [2:0]  prot;
    } req_t;

    typedef struct packed {
        logic        is_b;
        logic [1:0]  resp;
        logic [31:0] rdata;
    } rsp_t;

    logic        clk = 1'b0, rst = 1'b1;
    logic        awvalid = 0, awready, wvalid = 0, wready, bvalid, bready = 0;
    logic        arvalid = 0, arready, rvalid, rready = 0;
    logic [31:0] awaddr = 0, araddr = 0, wdata = 0, rdata;
    logic [2:0]  awprot = 0, arprot = 0;
    logic [3:0]  wstrb = 0;
    logic [1:0]  bresp, rresp;
    logic        req_valid, req_ready = 1'b1, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic [2:0]  req_prot;
    logic        rsp_valid = 0;
    logic [31:0] rsp_rdata = 0;
    logic [1:0]  rsp_resp = 0;

    int   errs = 0, checks = 0;
    req_t exp_req_q[$];
    rsp_t exp_rsp_q[$];

    always #5 clk = ~clk;

    axi_lite_slave_frontend #(.AW_AXI(32), .DW_AXI(32), .TIMEOUT_CYCLES(TO)) dut (
        .axi_clk(clk), .sys_areset(rst),
        .s_axi_awvalid(awvalid), .s_axi_awready(awready), .s_axi_awaddr(awaddr), .s_axi_awprot(awprot),
        .s_axi_wvalid(wvalid), .s_axi_wready(wready), .s_axi_wdata(wdata), .s_axi_wstrb(wstrb),
        .s_axi_bvalid(bvalid), .s_axi_bready(bready), .s_axi_bresp(bresp),
        .s_axi_arvalid(arvalid), .s_axi_arready(arready), .s_axi_araddr(araddr), .s_axi_arprot(arprot),
        .s_axi_rvalid(rvalid), .s_axi_rready(rready), .s_axi_rdata(rdata), .s_axi_rresp(rresp),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_be(req_be), .req_prot(req_prot),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp));

    // ---- drivers / observers (all called and returning on a falling edge) ----
    task automatic send_aw(input logic [31:0] a, input logic [2:0] p);
        int n = 0;
        awaddr = a; awprot = p; awvalid = 1'b1;
        while (!awready && n < 50) begin @(negedge clk); n++; end
        if (!awready) begin errs++; checks++; $display("FAIL aw_timeout awready=%b required=1", awready); end
        @(negedge clk); awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        wdata = d; wstrb = s; wvalid = 1'b1;
        while (!wready && n < 50) begin @(negedge clk); n++; end
        if (!wready) begin errs++; checks++; $display("FAIL w_timeout wready=%b required=1", wready); end
        @(negedge clk); wvalid = 1'b0;
    endtask

    task automatic send_ar(input logic [31:0] a, input logic [2:0] p);
        int n = 0;
        araddr = a; arprot = p; arvalid = 1'b1;
        while (!arready && n < 50) begin @(negedge clk); n++; end
        if (!arready) begin errs++; checks++; $display("FAIL ar_timeout arready=%b required=1", arready); end
        @(negedge clk); arvalid = 1'b0;
    endtask

    // Waits for req_valid, records the fields, returns after the handshake edge.
    // Write data is only meaningful for writes, so it is recorded as 0 for reads.
    task automatic get_req(output req_t g);
        int n = 0;
        while (!req_valid && n < 50) begin @(negedge clk); n++; end
        g = '{wr: req_write, addr: req_addr, data: (req_write ? req_wdata : 32'h0), be: req_be, prot: req_prot};
        if (!req_valid) begin errs++; checks++; $display("FAIL req_timeout req_valid=%b required=1", req_valid); end
        @(negedge clk);
    endtask

    // Pulses rsp_valid so the DUT samples it lat cycles after the handshake.
    task automatic respond(input int lat, input logic [1:0] r, input logic [31:0] d);
        repeat (lat - 1) @(negedge clk);
        rsp_valid = 1'b1; rsp_resp = r; rsp_rdata = d;
        @(negedge clk);
        rsp_valid = 1'b0; rsp_rdata = 32'h0; rsp_resp = 2'b00;
    endtask

    // Waits for bvalid or rvalid; steps past the handshake only if its ready is high.
    task automatic wait_resp(output rsp_t g);
        int n = 0;
        while (!bvalid && !rvalid && n < 60) begin @(negedge clk); n++; end
        g = '{is_b: bvalid, resp: (bvalid ? bresp : rresp), rdata: (bvalid ? 32'h0 : rdata)};
        if (!bvalid && !rvalid) begin errs++; checks++; $display("FAIL resp_timeout bvalid=%b rvalid=%b required=1", bvalid, rvalid); end
        if ((bvalid && bready) || (rvalid && rready)) @(negedge clk);
    endtask

    // ---- scenarios ----
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({awready, wready, arready, bvalid, rvalid, req_valid, req_be} !== 10'b0) begin
            errs++; $display("FAIL reset_outputs got %b required 0", {awready, wready, arready, bvalid, rvalid, req_valid, req_be});
        end
        rst = 1'b0;
        #1 checks++;
        if ({awready, wready, arready} !== 3'b000) begin
            errs++; $display("FAIL ready_at_release got %b required 000", {awready, wready, arready});
        end
        @(negedge clk);
        checks++;
        if ({awready, wready, arready} !== 3'b111) begin
            errs++; $display("FAIL ready_after_release got %b required 111", {awready, wready, arready});
        end
    endtask

    task automatic test_single_write();
        req_t g, e; rsp_t gr, er; logic held = 1'b1;
        bready = 1'b0;
        exp_req_q.push_back('{wr: 1'b1, addr: 32'h10, data: 32'hDEADBEEF, be: 4'hF, prot: 3'd0});
        exp_rsp_q.push_back('{is_b: 1'b1, resp: 2'b00, rdata: 32'h0});
        fork
            send_aw(32'h10, 3'd0);
            send_w(32'hDEADBEEF, 4'hF);
        join
        get_req(g); e = exp_req_q.pop_front(); checks++;
        if (g !== e) begin errs++; $display("FAIL single_write_req got %h required %h", g, e); end
        respond(3, 2'b00, 32'h0);
        wait_resp(gr); er = exp_rsp_q.pop_front(); checks++;
        if (gr !== er) begin errs++; $display("FAIL single_write_bresp got %h required %h", gr, er); end
        repeat (3) begin @(negedge clk); held &= bvalid && (bresp == 2'b00); end
        checks++;
        if (!held) begin errs++; $display("FAIL bvalid_held got %b required 1", held); end
        bready = 1'b1; @(negedge clk); bready = 1'b0;
        checks++;
        if (bvalid !== 1'b0) begin errs++; $display("FAIL bvalid_cleared got %b required 0", bvalid); end
    endtask

    task automatic test_w_before_aw();
        req_t g, e; rsp_t gr, er; logic wlow; int extra = 0;
        bready = 1'b1;
        exp_req_q.push_back('{wr: 1'b1, addr: 32'h20, data: 32'h1234, be: 4'hF, prot: 3'd0});
        exp_rsp_q.push_back('{is_b: 1'b1, resp: 2'b00, rdata: 32'h0});
        send_w(32'h1234, 4'hF);
        wlow = !wready;
        @(negedge clk); wlow &= !wready;
        send_aw(32'h20, 3'd0); wlow &= !wready;
        get_req(g); wlow &= !wready;
        e = exp_req_q.pop_front(); checks++;
        if (g !== e) begin errs++; $display("FAIL w_first_req got %h required %h", g, e); end
        respond(2, 2'b00, 32'h0); wlow &= !wready;
        wait_resp(gr); er = exp_rsp_q.pop_front(); checks++;
        if (gr !== er) begin errs++; $display("FAIL w_first_bresp got %h required %h", gr, er); end
        checks++;
        if (!wlow) begin errs++; $display("FAIL wready_low_in_flight got %b required 1", wlow); end
        checks++;
        if (wready !== 1'b1) begin errs++; $display("FAIL wready_after_b got %b required 1", wready); end
        repeat (5) begin @(negedge clk); if (req_valid) extra++; end
        checks++;
        if (extra != 0) begin errs++; $display("FAIL extra_request got %0d required 0", extra); end
        bready = 1'b0;
    endtask

    task automatic test_read_backpressure();
        req_t g, e; rsp_t gr, er; logic stable = 1'b1;
        rready = 1'b0;
        exp_req_q.push_back('{wr: 1'b0, addr: 32'h8, data: 32'h0, be: 4'hF, prot: 3'd2});
        exp_rsp_q.push_back('{is_b: 1'b0, resp: 2'b00, rdata: 32'hCAFE0001});
        send_ar(32'h8, 3'd2);
        get_req(g); e = exp_req_q.pop_front(); checks++;
        if (g !== e) begin errs++; $display("FAIL read_req got %h required %h", g, e); end
        respond(2, 2'b00, 32'hCAFE0001);
        wait_resp(gr); er = exp_rsp_q.pop_front(); checks++;
        if (gr !== er) begin errs++; $display("FAIL read_resp got %h required %h", gr, er); end
        repeat (5) begin
            @(negedge clk);
            stable &= rvalid && (rdata == 32'hCAFE0001) && (rresp == 2'b00) && !arready;
        end
        checks++;
        if (!stable) begin errs++; $display("FAIL r_stable_backpressure got %b required 1", stable); end
        rready = 1'b1; @(negedge clk); rready = 1'b0;
        checks++;
        if ({rvalid, arready} !== 2'b01) begin errs++; $display("FAIL r_after_handshake got %b required 01", {rvalid, arready}); end
    endtask

    task automatic test_round_robin();
        req_t g, e; rsp_t gr, er;
        test_reset();
        bready = 1'b1; rready = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            req_t rw, rr; rsp_t bw, br;
            rw = '{wr: 1'b1, addr: 32'h30 + 32'(pass), data: 32'h55AA55AA ^ 32'(pass), be: 4'h3, prot: 3'd1};
            rr = '{wr: 1'b0, addr: 32'h34 + 32'(pass), data: 32'h0, be: 4'hF, prot: 3'd4};
            bw = '{is_b: 1'b1, resp: 2'b00, rdata: 32'h0};
            br = '{is_b: 1'b0, resp: 2'b10, rdata: 32'h0BADF00D};
            if (pass == 0) begin
                exp_req_q.push_back(rw); exp_rsp_q.push_back(bw);
                exp_req_q.push_back(rr); exp_rsp_q.push_back(br);
            end else begin
                exp_req_q.push_back(rr); exp_rsp_q.push_back(br);
                exp_req_q.push_back(rw); exp_rsp_q.push_back(bw);
            end
            fork
                send_aw(rw.addr, rw.prot);
                send_w(rw.data, rw.be);
                send_ar(rr.addr, rr.prot);
            join
            for (int k = 0; k < 2; k++) begin
                get_req(g); e = exp_req_q.pop_front(); checks++;
                if (g !== e) begin errs++; $display("FAIL rr_req pass%0d slot%0d got %h required %h", pass, k, g, e); end
                respond(1, exp_rsp_q[0].resp, exp_rsp_q[0].rdata);
                wait_resp(gr); er = exp_rsp_q.pop_front(); checks++;
                if (gr !== er) begin errs++; $display("FAIL rr_rsp pass%0d slot%0d got %h required %h", pass, k, gr, er); end
            end
        end
        bready = 1'b0; rready = 1'b0;
    endtask

    task automatic test_timeout();
        req_t g, e; rsp_t gr, er; int n = 0; int stray = 0;
        rready = 1'b0;
        exp_req_q.push_back('{wr: 1'b0, addr: 32'h4, data: 32'h0, be: 4'hF, prot: 3'd0});
        exp_rsp_q.push_back('{is_b: 1'b0, resp: 2'b10, rdata: 32'h0});
        send_ar(32'h4, 3'd0);
        get_req(g); e = exp_req_q.pop_front(); checks++;
        if (g !== e) begin errs++; $display("FAIL timeout_req got %h required %h", g, e); end
        while (!rvalid && n < 30) begin @(negedge clk); n++; end
        checks++;
        if (!rvalid || n < TO || n > TO + 2) begin
            errs++; $display("FAIL timeout_latency got rvalid=%b after %0d cycles required %0d..%0d", rvalid, n, TO, TO + 2);
        end
        wait_resp(gr); er = exp_rsp_q.pop_front(); checks++;
        if (gr !== er) begin errs++; $display("FAIL timeout_resp got %h required %h", gr, er); end
        rsp_valid = 1'b1; rsp_resp = 2'b00; rsp_rdata = 32'hFFFF0000;
        @(negedge clk);
        rsp_valid = 1'b0; rsp_rdata = 32'h0;
        checks++;
        if ({rvalid, rresp, rdata} !== {1'b1, 2'b10, 32'h0}) begin
            errs++; $display("FAIL late_rsp_ignored got %b/%b/%h required 1/10/0", rvalid, rresp, rdata);
        end
        rready = 1'b1; @(negedge clk); rready = 1'b0;
        rsp_valid = 1'b1; @(negedge clk); rsp_valid = 1'b0;
        repeat (4) begin if (bvalid || rvalid || req_valid) stray++; @(negedge clk); end
        checks++;
        if (stray != 0) begin errs++; $display("FAIL idle_rsp_ignored got %0d stray cycles required 0", stray); end
    endtask

    task automatic test_reset_mid();
        req_t g, e; int stray = 0;
        bready = 1'b1; rready = 1'b1;
        exp_req_q.push_back('{wr: 1'b1, addr: 32'h40, data: 32'h77, be: 4'hF, prot: 3'd0});
        fork
            send_aw(32'h40, 3'd0);
            send_w(32'h77, 4'hF);
        join
        get_req(g); e = exp_req_q.pop_front(); checks++;
        if (g !== e) begin errs++; $display("FAIL reset_mid_req got %h required %h", g, e); end
        @(negedge clk);
        #2 rst = 1'b1;
        #1 checks++;
        if ({awready, wready, arready, bvalid, rvalid, req_valid} !== 6'b0) begin
            errs++; $display("FAIL async_reset got %b required 000000", {awready, wready, arready, bvalid, rvalid, req_valid});
        end
        @(negedge clk); rsp_valid = 1'b1;
        @(negedge clk); rsp_valid = 1'b0; rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({awready, wready, arready} !== 3'b111) begin
            errs++; $display("FAIL ready_after_mid_reset got %b required 111", {awready, wready, arready});
        end
        rsp_valid = 1'b1; @(negedge clk); rsp_valid = 1'b0;
        repeat (8) begin if (bvalid || rvalid || req_valid) stray++; @(negedge clk); end
        checks++;
        if (stray != 0) begin errs++; $display("FAIL stray_after_reset got %0d cycles required 0", stray); end
        bready = 1'b0; rready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_w_before_aw();
        test_read_backpressure();
        test_round_robin();
        test_timeout();
        test_reset_mid();
        checks++;
        if (exp_req_q.size() != 0 || exp_rsp_q.size() != 0) begin
            errs++; $display("FAIL scoreboard_drain got %0d/%0d entries required 0/0", exp_req_q.size(), exp_rsp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
